nibble_serial_alu_sequencer: RTL

// Multi-cycle WIDTH-bit add/subtract unit built around a single 4-bit lookahead adder slice.
// The slice is time-shared: one nibble per cycle, LSB first, with carry chained through a flop.

---
 rtl/nibble_serial_alu_sequencer_pkg.sv | 17 +
 rtl/nibble_serial_alu_sequencer_cla4_slice.sv | 39 +++
 rtl/nibble_serial_alu_sequencer.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/nibble_serial_alu_sequencer_pkg.sv
// Shared types and constants for the nibble-serial add/subtract sequencer.
package nibble_serial_alu_sequencer_pkg;

   localparam int NIBBLE_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Two's-complement overflow: operands share a sign and the result sign differs.
   function automatic logic signed_overflow(input logic a_msb, input logic b_msb, input logic r_msb);
      return (a_msb == b_msb) && (r_msb != a_msb);
   endfunction

endpackage

// File: rtl/nibble_serial_alu_sequencer_cla4_slice.sv
// 4-bit carry-lookahead adder slice, time-shared by the sequencer one nibble per cycle.
module nibble_serial_alu_sequencer_cla4_slice
   import nibble_serial_alu_sequencer_pkg::*;
(
   input  logic [NIBBLE_W-1:0] a,
   input  logic [NIBBLE_W-1:0] b,
   input  logic                cin,
   output logic [NIBBLE_W-1:0] sum,
   output logic                cout,
   output logic                prop,
   output logic                gen
);

   logic [NIBBLE_W-1:0] p_s;
   logic [NIBBLE_W-1:0] g_s;
   logic [NIBBLE_W:0]   c_s;

   assign p_s = a ^ b;
   assign g_s = a & b;

   // Group propagate/generate for the whole nibble.
   assign prop = &p_s;
   assign gen  = g_s[3]
               | (p_s[3] & g_s[2])
               | (p_s[3] & p_s[2] & g_s[1])
               | (p_s[3] & p_s[2] & p_s[1] & g_s[0]);

   // Internal carries computed in parallel from the incoming carry.
   assign c_s[0] = cin;
   assign c_s[1] = g_s[0] | (p_s[0] & cin);
   assign c_s[2] = g_s[1] | (p_s[1] & g_s[0]) | (p_s[1] & p_s[0] & cin);
   assign c_s[3] = g_s[2] | (p_s[2] & g_s[1]) | (p_s[2] & p_s[1] & g_s[0])
                 | (p_s[2] & p_s[1] & p_s[0] & cin);
   assign c_s[4] = gen | (prop & cin);

   assign sum  = p_s ^ c_s[NIBBLE_W-1:0];
   assign cout = c_s[NIBBLE_W];

endmodule

// File: rtl/nibble_serial_alu_sequencer.sv
// Multi-cycle WIDTH-bit add/subtract: one nibble per cycle through a shared CLA slice,
// LSB first, carry chained through a flop, valid/ready on request and result sides.
module nibble_serial_alu_sequencer
   import nibble_serial_alu_sequencer_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic             op_sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             carry_out,
   output logic             overflow,
   output logic             zero
);

   localparam int NIBBLES = WIDTH / NIBBLE_W;
   localparam int IDX_W   = $clog2(NIBBLES);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

   state_t state_r;
   state_t state_next_s;

   logic [WIDTH-1:0] a_r;
   logic [WIDTH-1:0] b_r;          // already inverted for subtract
   logic             carry_r;
   logic [IDX_W-1:0] idx_r;
   logic [WIDTH-1:0] result_r;
   logic             carry_out_r;
   logic             overflow_r;
   logic             zero_r;
   logic             in_ready_r;
   logic             out_valid_r;

   logic [NIBBLE_W-1:0] slice_a_s;
   logic [NIBBLE_W-1:0] slice_b_s;
   logic [NIBBLE_W-1:0] slice_sum_s;
   logic                slice_cout_s;
   logic                slice_prop_unused_s;
   logic                slice_gen_unused_s;
   logic [WIDTH-1:0]    result_next_s;
   logic                last_s;
   logic                zero_next_s;
   logic                overflow_next_s;

   nibble_serial_alu_sequencer_cla4_slice u_slice (
      .a    (slice_a_s),
      .b    (slice_b_s),
      .cin  (carry_r),
      .sum  (slice_sum_s),
      .cout (slice_cout_s),
      .prop (slice_prop_unused_s),
      .gen  (slice_gen_unused_s)
   );

   assign last_s = (idx_r == LAST_IDX);

   // Select the current operand nibbles with an index-driven AND-OR mux.
   always_comb begin
      slice_a_s = '0;
      slice_b_s = '0;
      for (int i = 0; i < NIBBLES; i++) begin
         slice_a_s = slice_a_s | (a_r[i*NIBBLE_W +: NIBBLE_W] & {NIBBLE_W{idx_r == IDX_W'(i)}});
         slice_b_s = slice_b_s | (b_r[i*NIBBLE_W +: NIBBLE_W] & {NIBBLE_W{idx_r == IDX_W'(i)}});
      end
   end

   // Insert the fresh sum nibble into the result and derive flags from the assembled word.
   always_comb begin
      result_next_s = result_r;
      for (int i = 0; i < NIBBLES; i++) begin
         result_next_s[i*NIBBLE_W +: NIBBLE_W] = (idx_r == IDX_W'(i)) ? slice_sum_s
                                                 : result_r[i*NIBBLE_W +: NIBBLE_W];
      end
      zero_next_s     = ~|result_next_s;
      overflow_next_s = signed_overflow(a_r[WIDTH-1], b_r[WIDTH-1], result_next_s[WIDTH-1]);
   end

   // Next-state decode for the IDLE -> RUN -> DONE handshake sequence.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (in_valid) begin
               state_next_s = ST_RUN;
            end else begin
               state_next_s = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (last_s) begin
               state_next_s = ST_DONE;
            end else begin
               state_next_s = ST_RUN;
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               state_next_s = ST_IDLE;
            end else begin
               state_next_s = ST_DONE;
            end
         end
         default: state_next_s = ST_IDLE;
      endcase
   end

   // State register plus registered handshake outputs derived from the next state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= ST_IDLE;
         in_ready_r  <= 1'b1;
         out_valid_r <= 1'b0;
      end else begin
         state_r     <= state_next_s;
         in_ready_r  <= (state_next_s == ST_IDLE);
         out_valid_r <= (state_next_s == ST_DONE);
      end
   end

   // Datapath: latch operands on accept, step one nibble per RUN cycle, capture flags at the end.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_r         <= '0;
         b_r         <= '0;
         carry_r     <= 1'b0;
         idx_r       <= '0;
         result_r    <= '0;
         carry_out_r <= 1'b0;
         overflow_r  <= 1'b0;
         zero_r      <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (in_valid) begin
                  a_r         <= op_a;
                  b_r         <= op_b ^ {WIDTH{op_sub}};
                  carry_r     <= op_sub;
                  idx_r       <= '0;
                  result_r    <= '0;
                  carry_out_r <= 1'b0;
                  overflow_r  <= 1'b0;
                  zero_r      <= 1'b0;
               end else begin
                  idx_r <= idx_r;
               end
            end
            ST_RUN: begin
               result_r <= result_next_s;
               carry_r  <= slice_cout_s;
               if (last_s) begin
                  idx_r       <= '0;
                  carry_out_r <= slice_cout_s;
                  overflow_r  <= overflow_next_s;
                  zero_r      <= zero_next_s;
               end else begin
                  idx_r <= idx_r + IDX_W'(1);
               end
            end
            ST_DONE: begin
               result_r <= result_r;
            end
            default: begin
               idx_r <= '0;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_r;
   assign out_valid = out_valid_r;
   assign result    = result_r;
   assign carry_out = carry_out_r;
   assign overflow  = overflow_r;
   assign zero      = zero_r;

endmodule
